// File: rtl/step_pkg.sv
// Shared constants, state type and step-count range check for the step sequencer.
package step_pkg;

    localparam int STEP_W    = 4;
    localparam int LED_W     = 10;
    localparam int MIN_STEPS = 1;
    localparam int MAX_STEPS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } step_state_t;

    // A run is accepted only for counts that map onto an actual LED.
    function automatic logic steps_legal(input logic [STEP_W-1:0] s);
        return (s >= STEP_W'(MIN_STEPS)) && (s <= STEP_W'(MAX_STEPS));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running dwell counter: tick pulses in the terminal-count cycle while enabled.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = en & w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Timed LED walk from step 1 up to a latched count; one step per TICK_DIV cycles.
// Define STEP_THERMO_EN for a thermometer LED code instead of one-hot.
module step_sequencer
    import step_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] steps,
    input  logic              start,
    input  logic              stop,
    output logic [LED_W-1:0]  led,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              done,
    output step_state_t       dbg_state
);

    step_state_t       r_state;
    logic [STEP_W-1:0] r_tgt;
    logic [STEP_W-1:0] r_step_idx;
    logic [LED_W-1:0]  r_led;
    logic              r_busy;
    logic              r_done;
    logic              w_tick;
    logic              w_pre_clr;

    function automatic logic [LED_W-1:0] led_decode(input logic [STEP_W-1:0] idx);
`ifdef STEP_THERMO_EN
        // Modular subtraction makes idx=LED_W wrap to all-ones.
        return (LED_W'(1) << idx) - LED_W'(1);
`else
        return (idx == '0) ? '0 : (LED_W'(1) << (idx - STEP_W'(1)));
`endif
    endfunction

    // Held clear outside RUN so every run starts with a full dwell.
    assign w_pre_clr = (r_state != RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_pre_clr),
        .en    (r_state == RUN),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tgt      <= '0;
            r_step_idx <= '0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !stop && steps_legal(steps)) begin
                        r_state    <= RUN;
                        r_tgt      <= steps;
                        r_step_idx <= STEP_W'(1);
                        r_led      <= led_decode(STEP_W'(1));
                        r_busy     <= 1'b1;
                    end else begin
                        r_step_idx <= '0;
                        r_led      <= '0;
                        r_busy     <= 1'b0;
                    end
                end
                RUN: begin
                    // Abort takes priority over a coincident tick.
                    if (stop) begin
                        r_state    <= IDLE;
                        r_step_idx <= '0;
                        r_led      <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b0;
                    end else if (w_tick) begin
                        if (r_step_idx < r_tgt) begin
                            r_step_idx <= r_step_idx + STEP_W'(1);
                            r_led      <= led_decode(r_step_idx + STEP_W'(1));
                        end else begin
                            r_state    <= DONE;
                            r_step_idx <= '0;
                            r_led      <= '0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_step_idx <= '0;
                    r_led      <= '0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_step_idx <= '0;
                    r_led      <= '0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign led       = r_led;
    assign step_idx  = r_step_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized and directed bench for step_sequencer with TICK_DIV=4 against a timeline model.
module tb_step_sequencer;
    import step_pkg::*;

    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [STEP_W-1:0] steps = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [LED_W-1:0]  led;
    logic [STEP_W-1:0] step_idx;
    logic              busy;
    logic              done;
    step_state_t       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: a run is the first RUN cycle plus the latched count.
    int cyc = 0;
    int m_run_start = -1;
    int m_tgt = 0;
    int last_done_cyc = -1;
    int done_cnt = 0;
    int busy_cnt = 0;

    step_sequencer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .steps     (steps),
        .start     (start),
        .stop      (stop),
        .led       (led),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [LED_W-1:0] exp_led(input int idx);
        logic [LED_W-1:0] v;
        v = '0;
        for (int b = 0; b < LED_W; b++) begin
`ifdef STEP_THERMO_EN
            if (b < idx) v[b] = 1'b1;
`else
            if (b == idx - 1) v[b] = 1'b1;
`endif
        end
        return v;
    endfunction

    task automatic model_edge(input logic s_start, input logic s_stop, input logic [STEP_W-1:0] s_steps);
        int  p;
        bit  running;
        bit  idle;
        p = cyc;
        running = (m_run_start >= 0) && (p - m_run_start < m_tgt * TD);
        idle    = !((m_run_start >= 0) && (p - m_run_start <= m_tgt * TD));
        if (running && s_stop) begin
            m_run_start = -1;
        end else if (idle && s_start && !s_stop && s_steps >= 1 && s_steps <= 10) begin
            m_run_start = p + 1;
            m_tgt = s_steps;
        end
        cyc = p + 1;
    endtask

    task automatic check_outputs();
        int k;
        int e_idx;
        logic e_busy;
        logic e_done;
        e_idx = 0; e_busy = 1'b0; e_done = 1'b0;
        if (m_run_start >= 0) begin
            k = cyc - m_run_start;
            if (k < m_tgt * TD) begin
                e_busy = 1'b1;
                e_idx  = k / TD + 1;
            end else if (k == m_tgt * TD) begin
                e_done = 1'b1;
            end
        end
        check("led", 32'(led), 32'(exp_led(e_idx)));
        check("step_idx", 32'(step_idx), 32'(e_idx));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        if (done) begin
            last_done_cyc = cyc;
            done_cnt++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic drive(input logic s_start, input logic s_stop, input logic [STEP_W-1:0] s_steps);
        start = s_start;
        stop  = s_stop;
        steps = s_steps;
        @(posedge clk);
        model_edge(s_start, s_stop, s_steps);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0);
    endtask

    int n0;

    initial begin
        // Reset held with start asserted
        start = 1'b1; steps = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_idx", 32'(step_idx), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        m_run_start = -1;
        idle_cycles(9);

        // Normal run of 3 steps
        n0 = cyc;
        drive(1'b1, 1'b0, 4'd3);
        idle_cycles(15);
        check("normal_done_cyc", 32'(last_done_cyc), 32'(n0 + 1 + 3 * TD));

        // Illegal counts
        done_cnt = 0; busy_cnt = 0;
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 4'd12);
        idle_cycles(50);
        check("illegal_done_cnt", 32'(done_cnt), 32'h0);
        check("illegal_busy_cnt", 32'(busy_cnt), 32'h0);

        // Abort during step 2
        done_cnt = 0;
        drive(1'b1, 1'b0, 4'd5);
        idle_cycles(5);
        drive(1'b0, 1'b1, 4'd5);
        idle_cycles(30);
        check("abort_done_cnt", 32'(done_cnt), 32'h0);

        // Abort coincident with the first tick
        drive(1'b1, 1'b0, 4'd5);
        idle_cycles(3);
        drive(1'b0, 1'b1, 4'd5);
        idle_cycles(25);
        check("abort_tick_done_cnt", 32'(done_cnt), 32'h0);

        // Full range with steps/start changes during RUN
        n0 = cyc;
        drive(1'b1, 1'b0, 4'd10);
        drive(1'b1, 1'b0, 4'd2);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 4'd2);
        check("full_done_cyc", 32'(last_done_cyc), 32'(n0 + 1 + 10 * TD));
        drive(1'b0, 1'b1, 4'd0);
        idle_cycles(3);

        // Back-to-back with start held high
        done_cnt = 0;
        n0 = cyc;
        for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, 4'd1);
        check("b2b_done_cnt", 32'(done_cnt), 32'd3);
        check("b2b_last_done", 32'(last_done_cyc), 32'(n0 + 17));
        idle_cycles(3);

        // Asynchronous reset mid-run
        drive(1'b1, 1'b0, 4'd5);
        idle_cycles(6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_idx", 32'(step_idx), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_run_start = -1;
        cyc = cyc + 1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
